sdram_refresh_executor: RTL and testbench
=========================================

# sdram_refresh_executor

Consumer of the refresh-request stream produced by the SDRAM refresh timer. Queues incoming refresh requests and arbitrates for the SDRAM command bus with the AHB-side access controller. Once granted the bus, it drives the PRECHARGE ALL → AUTO REFRESH command sequence with tRP/tRFC spacing, then releases the bus. Its `sdram_ready_o` feeds back as the timer's `sdram_ready_i`.

## Interface
- `T_RP_CYCLES`, 2, PRECHARGE-to-command spacing in HCLK cycles (≥1)
- `T_RFC_CYCLES`, 7, AUTO REFRESH-to-command spacing in HCLK cycles (≥2)
- `MAX_PENDING`, 8, maximum queued refreshes (JEDEC postpone limit)
- `URGENT_THRESH`, 6, pending count at which `urgent_o` asserts (1..MAX_PENDING)
- `HCLK`  in  1  single clock for the block
- `HRESET`  in  1  reset; synchronous, active-high
- `init_done_i`  in  1  SDRAM power-up initialization complete
- `refresh_req_i`  in  1  one-cycle refresh request pulse from the refresh timer
- `bus_gnt_i`  in  1  command-bus grant from the access controller
- `sdram_ready_o`  out  1  queue can accept a request (= `init_done_i` && pending < MAX_PENDING)
- `bus_req_o`  out  1  command-bus request; held until RELEASE
- `urgent_o`  out  1  pending ≥ URGENT_THRESH; access controller must close its open transaction
- `cmd_o`  out  4  {CSn,RASn,CASn,WEn}
- `a10_o`  out  1  address bit 10 (1 = all banks during PRECHARGE)
- `refresh_done_o`  out  1  one-cycle pulse in the RELEASE state
- `pending_cnt_o`  out  $clog2(MAX_PENDING+1)  queued refresh count
- `overflow_o`  out  1  sticky: a request was dropped because the queue was full

## Operation
- Reset values: state IDLE, `cmd_o`=NOP 4'b0111, `a10_o`=0, `bus_req_o`=0, `refresh_done_o`=0, `pending_cnt_o`=0, `overflow_o`=0, `urgent_o`=0. `sdram_ready_o` follows `init_done_i`.
- Pending counter:
  - +1 on `refresh_req_i` when `init_done_i`=1 and pending < MAX_PENDING.
  - −1 in every cycle where AUTO REFRESH is driven.
  - Simultaneous +1 and −1: count unchanged.
  - Request arriving with the queue full: dropped, `overflow_o` set (cleared only by reset).
  - Request arriving with `init_done_i`=0: ignored, no flag.
- Command encodings: NOP 0111, PRECHARGE 0010 (with `a10_o`=1), AUTO REFRESH 0001. `cmd_o` is NOP in every state except PRE and REF. `a10_o`=1 only in PRE.
- FSM:
  - IDLE → REQ when pending ≠ 0.
  - REQ (`bus_req_o`=1) → PRE on the edge where `bus_gnt_i`=1 is sampled.
  - PRE (1 cycle) → WAIT_RP for T_RP_CYCLES−1 cycles (skipped if 0) → REF.
  - REF (1 cycle) → WAIT_RFC for T_RFC_CYCLES−1 cycles.
  - End of WAIT_RFC:
    - If pending ≠ 0 (value after REF's decrement), go directly to REF. This is batching: no new precharge, and the bus is kept.
    - Otherwise go to RELEASE.
  - RELEASE (1 cycle; `bus_req_o`=0, `refresh_done_o`=1) → IDLE.
- `bus_req_o`=1 in REQ, PRE, WAIT_RP, REF, WAIT_RFC.
- `bus_gnt_i` is sampled only in REQ. The access controller must hold the grant until `bus_req_o` falls; the FSM does not react to a grant drop afterwards.
- `init_done_i` falling mid-sequence does not abort the sequence. The queue stops accepting requests.
- HRESET mid-sequence: all outputs return to reset values on the next edge, and queued refreshes are discarded.

## Timing
- The request pulse in cycle n makes pending visible in n+1 and puts REQ in n+2.
- Grant seen in cycle g: PRE in g+1, REF in g+1+T_RP_CYCLES.
- REF in cycle r: next REF (batched) or RELEASE in r+T_RFC_CYCLES. The access controller may drive commands from r+T_RFC_CYCLES+1.
- `urgent_o` and `sdram_ready_o` are combinational from the registered count and `init_done_i`.

## Structure
- Shared package `sdram_cmd_pkg`:
  - command encodings (NOP, PRECHARGE, AUTO_REFRESH, ACTIVE, READ, WRITE, MRS), shared with the access controller;
  - the FSM state enum.
- One sub-module, `sdram_wait_counter`: a loadable down-counter with a `zero_o` flag, instantiated once and reloaded for both the tRP and tRFC waits.

## Test plan
All scenarios use default parameters unless stated.
- Single request: pulse in cycle 0, `bus_gnt_i` high from cycle 3 → pending=1 in cycle 1; `bus_req_o`=1 from cycle 2; PRE with `a10_o`=1 in cycle 4; REF in cycle 6; pending=0 in cycle 7; `refresh_done_o` pulse and `bus_req_o`=0 in cycle 13.
- Batching: 3 pulses with grant low, then grant high → one PRE, REF at r, r+7, r+14; RELEASE at r+21; pending 3→0.
- Overflow: 9 pulses with grant low → pending=8 and `sdram_ready_o`=0 after the 8th; `overflow_o`=1 after the 9th; pending stays 8.
- Urgency: 6 pulses → `urgent_o`=1 once pending=6; after grant, `urgent_o`=0 in the cycle after the first REF (pending=5).
- Init gating: `init_done_i`=0 with 4 pulses → pending=0, `sdram_ready_o`=0, `bus_req_o`=0, `cmd_o`=0111 throughout.
- Reset mid-sequence: HRESET=1 during WAIT_RFC with pending=2 → next cycle: IDLE, `cmd_o`=0111, `bus_req_o`=0, pending=0, `overflow_o`=0.

Source files
------------

// File: rtl/sdram_cmd_pkg.sv
// sdram_cmd_pkg: SDRAM command encodings {CSn,RASn,CASn,WEn} and the refresh executor state set
package sdram_cmd_pkg;
  localparam logic [3:0] CMD_NOP          = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
  localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
  localparam logic [3:0] CMD_READ         = 4'b0101;
  localparam logic [3:0] CMD_WRITE        = 4'b0100;
  localparam logic [3:0] CMD_MRS          = 4'b0000;
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_PRE      = 3'd2,
    ST_WAIT_RP  = 3'd3,
    ST_REF      = 3'd4,
    ST_WAIT_RFC = 3'd5,
    ST_RELEASE  = 3'd6
  } refresh_state_e;
endpackage

// File: rtl/sdram_wait_counter.sv
// sdram_wait_counter: loadable down-counter that parks at zero and flags it
module sdram_wait_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/sdram_refresh_executor.sv
// sdram_refresh_executor: queues refresh requests and runs PRECHARGE ALL / AUTO REFRESH bursts on the shared command bus
module sdram_refresh_executor
  import sdram_cmd_pkg::*;
#(
  parameter int T_RP_CYCLES   = 2,
  parameter int T_RFC_CYCLES  = 7,
  parameter int MAX_PENDING   = 8,
  parameter int URGENT_THRESH = 6
) (
  input  logic                               HCLK,
  input  logic                               HRESET,
  input  logic                               init_done_i,
  input  logic                               refresh_req_i,
  input  logic                               bus_gnt_i,
  output logic                               sdram_ready_o,
  output logic                               bus_req_o,
  output logic                               urgent_o,
  output logic [3:0]                         cmd_o,
  output logic                               a10_o,
  output logic                               refresh_done_o,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending_cnt_o,
  output logic                               overflow_o
);
  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam int WW = $clog2((T_RFC_CYCLES > T_RP_CYCLES ? T_RFC_CYCLES : T_RP_CYCLES) + 1);
  // Loads are two below the spacing: one cycle is the command itself, one is the zero-detect cycle
  localparam logic [WW-1:0] RP_LOAD  = WW'(T_RP_CYCLES >= 2 ? T_RP_CYCLES - 2 : 0);
  localparam logic [WW-1:0] RFC_LOAD = WW'(T_RFC_CYCLES - 2);
  refresh_state_e state_q, state_d;
  logic [PW-1:0] pend_q, pend_d;
  logic ovf_q, ovf_d, full, accept, wait_load, wait_zero;
  logic [WW-1:0] wait_val;
  always_comb begin
    full      = pend_q == PW'(MAX_PENDING);
    accept    = refresh_req_i && init_done_i && !full;
    pend_d    = pend_q + PW'(accept) - PW'(state_q == ST_REF);
    ovf_d     = ovf_q || (refresh_req_i && init_done_i && full);
    wait_load = state_q == ST_PRE || state_q == ST_REF;
    wait_val  = state_q == ST_PRE ? RP_LOAD : RFC_LOAD;
    state_d   = state_q;
    case (state_q)
      ST_IDLE:     state_d = pend_q != '0 ? ST_REQ : ST_IDLE;
      ST_REQ:      state_d = bus_gnt_i ? ST_PRE : ST_REQ;
      ST_PRE:      state_d = T_RP_CYCLES > 1 ? ST_WAIT_RP : ST_REF;
      ST_WAIT_RP:  state_d = wait_zero ? ST_REF : ST_WAIT_RP;
      ST_REF:      state_d = ST_WAIT_RFC;
      ST_WAIT_RFC: state_d = !wait_zero ? ST_WAIT_RFC : (pend_q != '0 ? ST_REF : ST_RELEASE);
      ST_RELEASE:  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end
  sdram_wait_counter #(.W(WW)) u_wait (
    .clk        (HCLK),
    .rst        (HRESET),
    .load_i     (wait_load),
    .load_val_i (wait_val),
    .zero_o     (wait_zero)
  );
  assign sdram_ready_o  = init_done_i && !full;
  assign urgent_o       = pend_q >= PW'(URGENT_THRESH);
  assign bus_req_o      = state_q != ST_IDLE && state_q != ST_RELEASE;
  assign cmd_o          = state_q == ST_PRE ? CMD_PRECHARGE : (state_q == ST_REF ? CMD_AUTO_REFRESH : CMD_NOP);
  assign a10_o          = state_q == ST_PRE;
  assign refresh_done_o = state_q == ST_RELEASE;
  assign pending_cnt_o  = pend_q;
  assign overflow_o     = ovf_q;
endmodule

// File: tb/tb_sdram_refresh_executor.sv
// tb_sdram_refresh_executor: directed scenarios plus a random run against an event-timing reference model
module tb_sdram_refresh_executor;
  localparam int T_RP = 2, T_RFC = 7, MAXP = 8, URG = 6;
  logic HCLK = 1'b0, HRESET = 1'b1, init_done_i = 1'b0, refresh_req_i = 1'b0, bus_gnt_i = 1'b0;
  logic sdram_ready_o, bus_req_o, urgent_o, a10_o, refresh_done_o, overflow_o;
  logic [3:0] cmd_o, pending_cnt_o;
  logic [13:0] obs, exp_v;
  logic sent;
  int checks = 0, fails = 0;
  int m_pend = 0, m_phase = 0, m_last = 0, m_since = 0;
  logic m_ovf = 1'b0;

  sdram_refresh_executor #(
    .T_RP_CYCLES(T_RP), .T_RFC_CYCLES(T_RFC), .MAX_PENDING(MAXP), .URGENT_THRESH(URG)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .init_done_i(init_done_i), .refresh_req_i(refresh_req_i),
    .bus_gnt_i(bus_gnt_i), .sdram_ready_o(sdram_ready_o), .bus_req_o(bus_req_o), .urgent_o(urgent_o),
    .cmd_o(cmd_o), .a10_o(a10_o), .refresh_done_o(refresh_done_o), .pending_cnt_o(pending_cnt_o),
    .overflow_o(overflow_o)
  );

  always #5 HCLK = ~HCLK;

  assign obs = {bus_req_o, cmd_o, a10_o, refresh_done_o, pending_cnt_o, overflow_o, urgent_o, sdram_ready_o};

  // Reference model: phase 0 idle, 1 waiting for grant, 2 issuing commands, 3 release.
  // m_last is the last command issued (0 PRECHARGE, 1 AUTO REFRESH), m_since the cycles elapsed since it.
  always @(posedge HCLK) begin : model
    int np, ph, ls, sn;
    if (HRESET) begin
      m_pend <= 0; m_ovf <= 1'b0; m_phase <= 0; m_last <= 0; m_since <= 0;
    end else begin
      ph = m_phase; ls = m_last; sn = m_since;
      np = m_pend + ((refresh_req_i && init_done_i && m_pend < MAXP) ? 1 : 0)
                  - ((m_phase == 2 && m_since == 0 && m_last == 1) ? 1 : 0);
      if (ph == 0) begin
        if (m_pend != 0) ph = 1;
      end else if (ph == 1) begin
        if (bus_gnt_i) begin ph = 2; ls = 0; sn = 0; end
      end else if (ph == 2) begin
        sn = sn + 1;
        if (ls == 0 && sn == T_RP) begin ls = 1; sn = 0; end
        else if (ls == 1 && sn == T_RFC) begin
          if (m_pend != 0) sn = 0;
          else ph = 3;
        end
      end else ph = 0;
      m_pend  <= np;
      m_ovf   <= m_ovf | (refresh_req_i && init_done_i && m_pend == MAXP);
      m_phase <= ph; m_last <= ls; m_since <= sn;
    end
  end

  always_comb begin
    sent  = m_phase == 2 && m_since == 0;
    exp_v = {m_phase == 1 || m_phase == 2,
             sent ? (m_last == 0 ? 4'b0010 : 4'b0001) : 4'b0111,
             sent && m_last == 0, m_phase == 3, 4'(m_pend), m_ovf,
             m_pend >= URG, init_done_i && m_pend < MAXP};
  end

  task automatic step(input logic r, input logic g, input logic i, input logic h);
    @(negedge HCLK);
    refresh_req_i = r; bus_gnt_i = g; init_done_i = i; HRESET = h;
    #1;
  endtask

  task automatic do_reset;
    step(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset;
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== 14'b0_0111_0_0_0000_0_0_1) begin
      fails++; $display("FAIL reset_state got %b want %b", obs, 14'b0_0111_0_0_0000_0_0_1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (sdram_ready_o !== 1'b0) begin
      fails++; $display("FAIL reset_ready_follows_init got %b want 0", sdram_ready_o);
    end
  endtask

  task automatic test_single;
    logic [10:0] e;
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      step(c == 0, c >= 3 && c <= 13, 1'b1, 1'b0);
      e = {c >= 2 && c <= 12, c == 4 ? 4'b0010 : (c == 6 ? 4'b0001 : 4'b0111),
           c == 4, c == 13, (c >= 1 && c <= 6) ? 4'd1 : 4'd0};
      checks++;
      if (obs[13:3] !== e) begin
        fails++; $display("FAIL single c=%0d got %b want %b", c, obs[13:3], e);
      end
    end
  endtask

  task automatic test_batching;
    logic [10:0] e;
    int refs;
    do_reset();
    for (int c = 0; c <= 29; c++) begin
      step(c <= 2, c >= 4 && c <= 28, 1'b1, 1'b0);
      refs = int'(c > 7) + int'(c > 14) + int'(c > 21);
      e = {c >= 2 && c <= 27,
           c == 5 ? 4'b0010 : ((c == 7 || c == 14 || c == 21) ? 4'b0001 : 4'b0111),
           c == 5, c == 28, 4'(c < 3 ? c : 3 - refs)};
      checks++;
      if (obs[13:3] !== e) begin
        fails++; $display("FAIL batching c=%0d got %b want %b", c, obs[13:3], e);
      end
    end
  endtask

  task automatic test_overflow;
    logic [6:0] e;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      step(c <= 8, 1'b0, 1'b1, 1'b0);
      e = {4'(c > 8 ? 8 : c), c >= 9, c >= 6, c < 8};
      checks++;
      if (obs[6:0] !== e) begin
        fails++; $display("FAIL overflow c=%0d got %b want %b", c, obs[6:0], e);
      end
    end
  endtask

  task automatic test_urgency;
    int p;
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      step(c <= 5, c >= 7, 1'b1, 1'b0);
      p = c <= 6 ? c : (c <= 10 ? 6 : 5);
      checks++;
      if ({obs[6:3], urgent_o} !== {4'(p), p >= 6}) begin
        fails++; $display("FAIL urgency c=%0d got %b want %b", c, {obs[6:3], urgent_o}, {4'(p), p >= 6});
      end
    end
  endtask

  task automatic test_init_gating;
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      step(c % 2 == 0 && c < 8, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({obs[13:9], obs[6:2], sdram_ready_o} !== 11'b0_0111_0000_0_0) begin
        fails++; $display("FAIL init_gating c=%0d got %b want %b", c, {obs[13:9], obs[6:2], sdram_ready_o}, 11'b0_0111_0000_0_0);
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      step(c <= 2, c >= 2, 1'b1, c == 7);
      if (c == 7) begin
        checks++;
        if (obs[13:3] !== 11'b1_0111_0_0_0010) begin
          fails++; $display("FAIL reset_mid_before got %b want %b", obs[13:3], 11'b1_0111_0_0_0010);
        end
      end else if (c >= 8) begin
        checks++;
        if (obs[13:1] !== 13'b0_0111_0_0_0000_0_0) begin
          fails++; $display("FAIL reset_mid_after c=%0d got %b want %b", c, obs[13:1], 13'b0_0111_0_0_0000_0_0);
        end
      end
    end
  endtask

  task automatic test_random;
    logic g, ini;
    g = 1'b0; ini = 1'b1;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge HCLK);
      if ($urandom_range(199) == 0) ini = ~ini;
      if (m_phase == 1 || m_phase == 2) begin
        if (!g) g = $urandom_range(2) == 0;
      end else g = 1'b0;
      refresh_req_i = $urandom_range(7) == 0;
      HRESET        = $urandom_range(599) == 0;
      bus_gnt_i     = g;
      init_done_i   = ini;
      #1;
      checks++;
      if (obs !== exp_v) begin
        fails++; $display("FAIL random c=%0d got %b want %b", c, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_batching();
    test_overflow();
    test_urgency();
    test_init_gating();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
